// File: rtl/cpc_bus_pkg.sv
// Shared types for the CPC bus initiator: command codes, bus states, strobe bundle.
// bus_strobes() maps a bus state and command type to the active-low strobe set.
package cpc_bus_pkg;

  typedef enum logic [1:0] {
    CMD_MEMRD = 2'b00,
    CMD_MEMWR = 2'b01,
    CMD_IOWR  = 2'b10,
    CMD_M1    = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TWA  = 3'd3,
    S_TW   = 3'd4,
    S_T3   = 3'd5,
    S_T4   = 3'd6
  } state_e;

  localparam logic [7:0] WAIT_TIMEOUT = 8'd255;

  typedef struct packed {
    logic mreq_b;
    logic iorq_b;
    logic rd_b;
    logic wr_b;
    logic m1_b;
    logic rfsh_b;
  } strb_t;

  function automatic strb_t bus_strobes(input state_e st, input cmd_type_e typ);
    strb_t s;
    s = '1;
    case (st)
      S_T1: begin
        s.mreq_b = (typ == CMD_IOWR);
        s.rd_b   = !(typ == CMD_MEMRD || typ == CMD_M1);
        s.m1_b   = (typ != CMD_M1);
      end
      S_T2, S_TWA, S_TW, S_T3: begin
        if (typ == CMD_M1 && st == S_T3) begin
          // refresh half of the opcode fetch
          s.mreq_b = 1'b0;
          s.rfsh_b = 1'b0;
        end else begin
          s.mreq_b = (typ == CMD_IOWR);
          s.iorq_b = (typ != CMD_IOWR);
          s.rd_b   = !(typ == CMD_MEMRD || typ == CMD_M1);
          s.wr_b   = !(typ == CMD_MEMWR || typ == CMD_IOWR);
          s.m1_b   = (typ != CMD_M1);
        end
      end
      S_T4: s.rfsh_b = (typ != CMD_M1);
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cpc_wait_timer.sv
// Consecutive wait-state counter; expire marks the WAIT_TIMEOUT-th TW cycle.
// Built only when WAIT_TIMEOUT_EN is defined.
`ifdef WAIT_TIMEOUT_EN
module cpc_wait_timer
  import cpc_bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic count,
  input  logic clear,
  output logic expire
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)      cnt_d = '0;
    else if (count) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q holds the TW cycles already completed, so this is the last allowed one
  assign expire = count && (cnt_q == WAIT_TIMEOUT - 8'd1);

endmodule
`endif

// File: rtl/cpc_bus_initiator.sv
// Z80-style CPC bus initiator: one command in, one registered bus cycle out, one response pulse.
// WAIT_TIMEOUT_EN adds an abort after a run of wait states (rsp_err); otherwise waits are unbounded.
module cpc_bus_initiator
  import cpc_bus_pkg::*;
#(
  parameter logic [7:0] RFSH_HI = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] adr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        mreq_b,
  output logic        iorq_b,
  output logic        rd_b,
  output logic        wr_b,
  output logic        m1_b,
  output logic        rfsh_b,
  input  logic        ready
);

  state_e      state_q, state_d;
  cmd_type_e   typ_q, typ_d;
  strb_t       strb_q, strb_d;
  logic [15:0] adr_q, adr_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic [6:0]  r_q, r_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        accept;
  logic        timeout;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_ready && cmd_valid;

`ifdef WAIT_TIMEOUT_EN
  cpc_wait_timer u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .count  (state_q == S_TW),
    .clear  (state_q != S_TW),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    typ_d       = typ_q;
    adr_d       = adr_q;
    data_out_d  = data_out_q;
    r_d         = r_q;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: if (accept) begin
        state_d    = S_T1;
        typ_d      = cmd_type_e'(cmd_type);
        adr_d      = cmd_addr;
        data_out_d = cmd_wdata;
      end
      S_T1:  state_d = S_T2;
      S_T2:  if (typ_q == CMD_IOWR) state_d = S_TWA;
             else                   state_d = ready ? S_T3 : S_TW;
      S_TWA: state_d = ready ? S_T3 : S_TW;
      S_TW:  if (timeout)    state_d = S_IDLE;
             else if (ready) state_d = S_T3;
      S_T3:  state_d = (typ_q == CMD_M1) ? S_T4 : S_IDLE;
      S_T4:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (typ_d == CMD_M1 && state_d == S_T3) adr_d = {RFSH_HI, 1'b0, r_q};

    // opcode is latched as the fetch leaves T2/TW; plain reads latch at the end of T3
    if ((state_q == S_T3 && typ_q == CMD_MEMRD) ||
        (typ_q == CMD_M1 && state_d == S_T3 && state_q != S_T3))
      rdata_d = data_in;

    if (state_q == S_T4) r_d = r_q + 7'd1;

    strb_d      = bus_strobes(state_d, typ_d);
    data_oe_d   = (typ_d == CMD_MEMWR || typ_d == CMD_IOWR) &&
                  (state_d inside {S_T1, S_T2, S_TWA, S_TW, S_T3});
    rsp_valid_d = (state_q == S_T3 && typ_q != CMD_M1) || (state_q == S_T4) || timeout;
    rsp_err_d   = timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      typ_q       <= CMD_MEMRD;
      strb_q      <= '1;
      adr_q       <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      r_q         <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      typ_q       <= typ_d;
      strb_q      <= strb_d;
      adr_q       <= adr_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      r_q         <= r_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mreq_b    = strb_q.mreq_b;
  assign iorq_b    = strb_q.iorq_b;
  assign rd_b      = strb_q.rd_b;
  assign wr_b      = strb_q.wr_b;
  assign m1_b      = strb_q.m1_b;
  assign rfsh_b    = strb_q.rfsh_b;
  assign adr       = adr_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cpc_bus_initiator.sv
// Directed bench for cpc_bus_initiator: per-command strobe profiles, waits, refresh, reset, timeout.
module tb_cpc_bus_initiator;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] adr;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in;
  logic        mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b;
  logic        ready;

  cpc_bus_initiator dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .adr       (adr),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .data_in   (data_in),
    .mreq_b    (mreq_b),
    .iorq_b    (iorq_b),
    .rd_b      (rd_b),
    .wr_b      (wr_b),
    .m1_b      (m1_b),
    .rfsh_b    (rfsh_b),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] T_MEMRD = 2'b00;
  localparam logic [1:0] T_MEMWR = 2'b01;
  localparam logic [1:0] T_IOWR  = 2'b10;
  localparam logic [1:0] T_M1    = 2'b11;

  int n_checks;
  int n_errors;

  // per-command observations
  int          n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh, n_oe;
  int          rsp_cyc, m1_rf, adr_bad, dout_bad;
  logic        rsp_err_v, idle_ok;
  logic [15:0] rf_adr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b};
  endfunction

  // Call at a falling edge with the DUT idle; returns at the falling edge of cycle ncyc.
  // ready is low for 'lows' consecutive samples; data_in carries din only on the capture edge.
  task automatic run_cmd(input logic [1:0] typ, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] din, input int lows, input int ncyc);
    int samp, capc;
    samp = (typ == T_IOWR) ? 3 : 2;
    capc = (typ == T_M1) ? 2 + lows : 3 + lows;
    n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0; n_m1 = 0; n_rfsh = 0; n_oe = 0;
    rsp_cyc = 0; m1_rf = 0; adr_bad = 0; dout_bad = 0;
    rsp_err_v = 1'b0; idle_ok = 1'b0; rf_adr = 16'hFFFF;
    chk("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_type = typ; cmd_addr = a; cmd_wdata = wd;
    ready = 1'b1; data_in = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_type = ~typ; cmd_addr = ~a; cmd_wdata = ~wd;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (!mreq_b) n_mreq++;
      if (!iorq_b) n_iorq++;
      if (!rd_b)   n_rd++;
      if (!wr_b)   n_wr++;
      if (!m1_b)   n_m1++;
      if (!rfsh_b) begin n_rfsh++; rf_adr = adr; end
      if (data_oe) n_oe++;
      if (!m1_b && !rfsh_b) m1_rf++;
      if ((!mreq_b || !iorq_b || data_oe) && rfsh_b && adr !== a) adr_bad++;
      if (data_oe && data_out !== wd) dout_bad++;
      if (rsp_valid && rsp_cyc == 0) begin
        rsp_cyc   = c;
        rsp_err_v = rsp_err;
        idle_ok   = (strobes() == 6'h3F) && !data_oe && cmd_ready;
      end
      ready   = (c >= samp && c < samp + lows) ? 1'b0 : 1'b1;
      data_in = (c == capc) ? din : 8'h00;
    end
  endtask

  initial begin
    int seen;
    n_checks = 0; n_errors = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    data_in = '0; ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {26'd0, strobes()}, 32'h3F);
    chk("rst_adr", {16'd0, adr}, 32'h0);
    chk("rst_dout", {24'd0, data_out}, 32'h0);
    chk("rst_oe", {31'd0, data_oe}, 32'h0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'h0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'h0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'h1);
    reset = 1'b0;
    @(negedge clk);

    // bank-select I/O write
    run_cmd(T_IOWR, 16'h7F00, 8'hC2, 8'h00, 0, 5);
    chk("iowr_iorq", n_iorq, 3);
    chk("iowr_wr", n_wr, 3);
    chk("iowr_mreq", n_mreq, 0);
    chk("iowr_oe", n_oe, 4);
    chk("iowr_rsp_cyc", rsp_cyc, 5);
    chk("iowr_err", {31'd0, rsp_err_v}, 0);
    chk("iowr_adr", adr_bad, 0);
    chk("iowr_dout", dout_bad, 0);
    chk("iowr_idle", {31'd0, idle_ok}, 1);

    // memory read with two wait states
    run_cmd(T_MEMRD, 16'h4000, 8'h00, 8'hA5, 2, 6);
    chk("rdw_mreq", n_mreq, 5);
    chk("rdw_rd", n_rd, 5);
    chk("rdw_wr_oe", n_wr + n_oe, 0);
    chk("rdw_rsp_cyc", rsp_cyc, 6);
    chk("rdw_rdata", {24'd0, rsp_rdata}, 32'hA5);
    chk("rdw_adr", adr_bad, 0);

    // back-to-back read then write
    run_cmd(T_MEMRD, 16'h8001, 8'h00, 8'h3C, 0, 4);
    chk("rd_mreq", n_mreq, 3);
    chk("rd_rsp_cyc", rsp_cyc, 4);
    chk("rd_rdata", {24'd0, rsp_rdata}, 32'h3C);
    chk("rd_idle", {31'd0, idle_ok}, 1);
    run_cmd(T_MEMWR, 16'h1234, 8'h5A, 8'h00, 0, 4);
    chk("wr_mreq", n_mreq, 3);
    chk("wr_wr", n_wr, 2);
    chk("wr_oe", n_oe, 3);
    chk("wr_rd", n_rd, 0);
    chk("wr_rsp_cyc", rsp_cyc, 4);
    chk("wr_adr", adr_bad, 0);
    chk("wr_dout", dout_bad, 0);
    chk("wr_rdata_kept", {24'd0, rsp_rdata}, 32'h3C);

    // reset in the middle of a write's wait state
    run_cmd(T_MEMWR, 16'h2222, 8'h77, 8'h00, 10, 3);
    chk("rsttw_wr", n_wr, 2);
    reset = 1'b1;
    #1;
    chk("rsttw_strobes", {26'd0, strobes()}, 32'h3F);
    chk("rsttw_oe", {31'd0, data_oe}, 0);
    chk("rsttw_adr", {16'd0, adr}, 0);
    @(negedge clk);
    reset = 1'b0; ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rsttw_no_rsp", seen, 0);

    // opcode fetches from a fresh refresh counter
    run_cmd(T_M1, 16'h0100, 8'h00, 8'hED, 0, 5);
    chk("m1a_m1", n_m1, 2);
    chk("m1a_rfsh", n_rfsh, 2);
    chk("m1a_mreq", n_mreq, 3);
    chk("m1a_rd", n_rd, 2);
    chk("m1a_rf_adr", {16'd0, rf_adr}, 32'h0000);
    chk("m1a_m1_in_rfsh", m1_rf, 0);
    chk("m1a_adr", adr_bad, 0);
    chk("m1a_rsp_cyc", rsp_cyc, 5);
    chk("m1a_rdata", {24'd0, rsp_rdata}, 32'hED);
    run_cmd(T_M1, 16'h0100, 8'h00, 8'h21, 0, 5);
    chk("m1b_rf_adr", {16'd0, rf_adr}, 32'h0001);
    chk("m1b_rfsh", n_rfsh, 2);
    chk("m1b_rdata", {24'd0, rsp_rdata}, 32'h21);
    run_cmd(T_M1, 16'h0200, 8'h00, 8'h11, 1, 6);
    chk("m1w_m1", n_m1, 3);
    chk("m1w_rf_adr", {16'd0, rf_adr}, 32'h0002);
    chk("m1w_rsp_cyc", rsp_cyc, 6);
    chk("m1w_rdata", {24'd0, rsp_rdata}, 32'h11);

    // refresh counter wrap
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 129; i++) begin
      run_cmd(T_M1, 16'h0100, 8'h00, 8'(i), 0, 5);
      if (i == 127) chk("wrap_rf_127", {16'd0, rf_adr}, 32'h007F);
      if (i == 128) chk("wrap_rf_128", {16'd0, rf_adr}, 32'h0000);
    end

    // long wait: aborted with the timeout option, otherwise completes
    run_cmd(T_MEMRD, 16'hC000, 8'h00, 8'h99, 300, 310);
`ifdef WAIT_TIMEOUT_EN
    chk("tmo_rsp_cyc", rsp_cyc, 258);
    chk("tmo_err", {31'd0, rsp_err_v}, 1);
    chk("tmo_mreq", n_mreq, 257);
    chk("tmo_rdata", {24'd0, rsp_rdata}, 32'h80);
`else
    chk("tmo_rsp_cyc", rsp_cyc, 304);
    chk("tmo_err", {31'd0, rsp_err_v}, 0);
    chk("tmo_mreq", n_mreq, 303);
    chk("tmo_rdata", {24'd0, rsp_rdata}, 32'h99);
`endif
    chk("tmo_idle", {31'd0, idle_ok}, 1);

    run_cmd(T_M1, 16'h0100, 8'h00, 8'h44, 300, 310);
`ifdef WAIT_TIMEOUT_EN
    chk("tmo_m1_rsp_cyc", rsp_cyc, 258);
    chk("tmo_m1_err", {31'd0, rsp_err_v}, 1);
`else
    chk("tmo_m1_rsp_cyc", rsp_cyc, 305);
    chk("tmo_m1_err", {31'd0, rsp_err_v}, 0);
`endif
    run_cmd(T_M1, 16'h0100, 8'h00, 8'h55, 0, 5);
`ifdef WAIT_TIMEOUT_EN
    chk("tmo_r_kept", {16'd0, rf_adr}, 32'h0001);
`else
    chk("tmo_r_kept", {16'd0, rf_adr}, 32'h0002);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpc_bus_initiator.md
# cpc_bus_initiator

Synthesisable Z80-style bus initiator for the CPC RAM-expansion bench and bring-up harness. It turns single-transfer commands into cycle-accurate CPC bus cycles: memory read, memory write, I/O write and M1 opcode fetch with refresh. It drives the same strobes the expansion CPLD decodes, including the 0x7Fxx bank-select writes (0b11cccbbb), and returns read data and completion status to the command source.

## Interface
- Parameters
  - RFSH_HI, 8'h00: upper refresh address byte, the I-register stand-in.
- Ports: one clock; reset is asynchronous and active-high.
  - clk  in  1  bus clock; one period is one T-state.
  - reset  in  1  asynchronous, active-high.
  - cmd_valid  in  1  command offered.
  - cmd_ready  out  1  command accepted when high with cmd_valid at the rising edge.
  - cmd_type  in  2  00 MEMRD, 01 MEMWR, 10 IOWR, 11 M1.
  - cmd_addr  in  16  bus address.
  - cmd_wdata  in  8  write data.
  - rsp_valid  out  1  one-cycle completion pulse.
  - rsp_rdata  out  8  read data; holds its value until the next read completes.
  - rsp_err  out  1  qualified by rsp_valid; set only on a timeout abort.
  - adr  out  16  address bus.
  - data_out  out  8  write data.
  - data_oe  out  1  data bus drive enable.
  - data_in  in  8  read data.
  - mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b  out  1 each  active-low strobes.
  - ready  in  1  wait request; low inserts wait states.

## Operation
- States: IDLE, T1, T2, TWA, TW, T3, T4.
- cmd_ready = (state==IDLE). Acceptance registers the command; the next cycle is T1.
- All bus outputs are registered. In IDLE every strobe is high and data_oe=0.
- Strobes per type:
  - MEMRD: mreq_b=0 and rd_b=0 over T1..T3.
  - MEMWR: mreq_b=0 over T1..T3; wr_b=0 over T2..T3; data_oe=1 over T1..T3.
  - IOWR: iorq_b=0 and wr_b=0 over T2..T3; data_oe=1 over T1..T3; mandatory TWA after T2.
  - M1: m1_b=0, mreq_b=0, rd_b=0 over T1..T2(+TW). In T3 and T4, adr={RFSH_HI, 1'b0, r[6:0]} and rfsh_b=0; mreq_b=0 in T3 and 1 in T4.
- TW keeps the strobes of the preceding T2/TWA.
- Wait sampling: ready is sampled at the edge leaving T2 (memory) or TWA (I/O). ready=0 moves to TW. TW resamples every edge and exits to T3 on ready=1.
- Read capture into rsp_rdata:
  - MEMRD: at the edge leaving T3.
  - M1: at the edge leaving T2/TW.
- 7-bit refresh counter r increments after each M1. It wraps 0x7F→0x00; adr bit 7 of the refresh address stays 0.
- rsp_valid pulses in the IDLE cycle after the last bus state. Writes report completion only.
- Reset (asserted at any time, including mid-cycle): state=IDLE, all strobes 1, adr=0, data_out=0, data_oe=0, r=0, rsp_valid=0, rsp_err=0, rsp_rdata=0. An interrupted cycle produces no response.

## Timing
- Bus states without waits (each includes the acceptance→T1 cycle):
  - MEMRD and MEMWR: 3 bus states; rsp_valid 4 cycles after acceptance.
  - IOWR: 4 bus states (T1, T2, TWA, T3); rsp_valid at cycle 5.
  - M1: 4 bus states; rsp_valid at cycle 5.
- Each low ready sample adds exactly one TW.
- Back-to-back commands: at least one IDLE cycle, all strobes high, separates bus cycles.
- adr and data_out are stable from T1 to the end of the last state. cmd_* inputs are ignored after acceptance.

## Configuration
- WAIT_TIMEOUT_EN defined:
  - An 8-bit counter runs in TW.
  - On the 255th consecutive TW the cycle aborts: strobes release next cycle, state returns to IDLE, and the response is rsp_valid=1, rsp_err=1. rsp_rdata is unchanged and r is not incremented.
- Undefined: TW persists indefinitely and rsp_err is tied 0.

## Structure
- Package cpc_bus_pkg holds:
  - cmd_type codes CMD_MEMRD, CMD_MEMWR, CMD_IOWR, CMD_M1;
  - the state encoding;
  - WAIT_TIMEOUT = 8'd255.
- Sub-module cpc_wait_timer (count, clear, expire) exists only under WAIT_TIMEOUT_EN. All other logic stays flat in cpc_bus_initiator.

## Test plan
- IOWR adr 0x7F00, wdata 0xC2, ready=1 → iorq_b and wr_b low for exactly 3 cycles (T2, TWA, T3); data_out=0xC2; mreq_b stays high; rsp_valid at cycle 5, rsp_err=0.
- MEMRD 0x4000 with ready low for 2 samples, data_in=0xA5 → 2 TW; mreq_b and rd_b low for 5 cycles; rsp_rdata=0xA5.
- Two M1 fetches at 0x0100 from reset → refresh adr 0x0000, then 0x0001; rfsh_b low 2 cycles each; m1_b never low during T3/T4.
- 129 M1 fetches → the 129th refresh adr is 0x0000 (wrap), bit 7 stays 0.
- Reset asserted during TW of MEMWR → strobes high and data_oe=0 in the same cycle; no rsp_valid; the next command runs normally.
- WAIT_TIMEOUT_EN, ready held low → abort after 255 TW; rsp_valid=1, rsp_err=1; cmd_ready high the following cycle.
